// File: rtl/pwq_pkg.sv
// Shared types and constants for the pixel write queue.
// The optional pixel statistics counter in the top is enabled by defining PWQ_STATS_EN.
package pwq_pkg;

  localparam int PWQ_DEPTH    = 16;
  localparam int PWQ_SCREEN_W = 320;
  localparam int PWQ_SCREEN_H = 240;

  // One queued pixel write; 20 bits packed.
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } pixel_t;

  // Linear framebuffer address for a 320-wide screen: y*320 + x, done with shifts.
  function automatic logic [16:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    logic [16:0] yy;
    yy = {9'd0, y};
    return (yy << 8) + (yy << 6) + {8'd0, x};
  endfunction

endpackage

// File: rtl/pixel_write_queue_if.sv
// Pixel bus between the drawers, the write queue and the VGA adapter.
// Input side: in_valid is a single-cycle strobe with no ready; the queue either
// takes the pixel, filters it, or drops it and flags overflow.
// Output side: a pixel transfers on a rising clock edge where vga_plot and
// vga_ready are both high; while vga_plot=1 and vga_ready=0 the payload
// (vga_x/y/color/addr) is held stable and vga_plot stays high.
interface pixel_write_queue_if;
  logic        in_valid;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [2:0]  in_color;
  logic        vga_plot;
  logic        vga_ready;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_color;
  logic [16:0] vga_addr;

  // Drawer/adapter side.
  modport master (
    output in_valid, in_x, in_y, in_color, vga_ready,
    input  vga_plot, vga_x, vga_y, vga_color, vga_addr
  );

  // Queue side.
  modport slave (
    input  in_valid, in_x, in_y, in_color, vga_ready,
    output vga_plot, vga_x, vga_y, vga_color, vga_addr
  );
endinterface

// File: rtl/pwq_fifo_mem.sv
// Storage array for the pixel queue: synchronous write, asynchronous read of
// the head entry so the output stage can load it in the same cycle.
module pwq_fifo_mem
  import pwq_pkg::*;
#(
  parameter int DEPTH  = PWQ_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pixel_t            rdata
);

  pixel_t mem [DEPTH];

  // Write port; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_write_queue.sv
// Pixel write queue: filters off-screen pixels, buffers the rest in a small
// FIFO, and presents them to the VGA adapter through a one-entry output
// stage with address precomputed. A pixel arriving while the queue is empty
// and the output stage is free bypasses the FIFO (latency 1).
// Optional: define PWQ_STATS_EN to add the pix_count retired-pixel counter.
module pixel_write_queue
  import pwq_pkg::*;
#(
  parameter int DEPTH    = PWQ_DEPTH,
  parameter int SCREEN_W = PWQ_SCREEN_W,
  parameter int SCREEN_H = PWQ_SCREEN_H
) (
  input  logic                 clock,
  input  logic                 reset,
  pixel_write_queue_if.slave   bus,
  output logic                 full,
  output logic                 overflow,
  output logic                 idle
`ifdef PWQ_STATS_EN
  ,
  output logic [16:0]          pix_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [9:0]      X_LIMIT  = 10'(SCREEN_W);
  localparam logic [8:0]      Y_LIMIT  = 9'(SCREEN_H);
  localparam logic [16:0]     W_FACTOR = 17'(SCREEN_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;

  pixel_t      in_pix;
  pixel_t      head_pix;
  pixel_t      load_pix;
  pixel_t      out_pix;
  logic [16:0] out_addr;
  logic        plot;

  logic in_ok;
  logic fifo_empty;
  logic out_free;
  logic retire;
  logic bypass;
  logic pop;
  logic push;
  logic drop;
  logic load;

  // Linear address; shift form for the standard 320-wide screen.
  function automatic logic [16:0] lin_addr(input pixel_t p);
    if (SCREEN_W == 320) return pix_addr(p.x, p.y);
    else return 17'({9'd0, p.y} * W_FACTOR + {8'd0, p.x});
  endfunction

  assign in_pix = '{x: bus.in_x, y: bus.in_y, color: bus.in_color};

  // Off-screen pixels are treated as if never strobed.
  assign in_ok      = bus.in_valid && ({1'b0, bus.in_x} < X_LIMIT) && ({1'b0, bus.in_y} < Y_LIMIT);
  assign fifo_empty = (count == '0);
  assign retire     = plot && bus.vga_ready;
  assign out_free   = !plot || bus.vga_ready;

  // Output stage loads from the FIFO head when it has something, else directly
  // from the input; queued pixels always go first to preserve order.
  assign pop    = out_free && !fifo_empty;
  assign bypass = in_ok && fifo_empty && out_free;
  assign push   = in_ok && !bypass && ((count != DEPTH_C) || pop);
  assign drop   = in_ok && !bypass && !((count != DEPTH_C) || pop);
  assign load   = pop || bypass;

  // Select the pixel entering the output stage.
  always_comb begin
    load_pix = in_pix;
    if (pop) load_pix = head_pix;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (ADDR_W+1)'(1);
      2'b01:   count_next = count - (ADDR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  pwq_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_pix),
    .raddr (rd_ptr),
    .rdata (head_pix)
  );

  // Pointers, occupancy, registered full flag and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      if (drop) overflow <= 1'b1;
    end
  end

  // Output/skid stage: holds its payload until the adapter takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_pix  <= '0;
      out_addr <= '0;
      plot     <= 1'b0;
    end else if (load) begin
      out_pix  <= load_pix;
      out_addr <= lin_addr(load_pix);
      plot     <= 1'b1;
    end else if (retire) begin
      plot     <= 1'b0;
    end
  end

`ifdef PWQ_STATS_EN
  // Retired-pixel counter; a strobe at the origin restarts it, saturates at max.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_count <= '0;
    end else if (bus.in_valid && (bus.in_x == 9'd0) && (bus.in_y == 8'd0)) begin
      pix_count <= '0;
    end else if (retire && (pix_count != 17'h1FFFF)) begin
      pix_count <= pix_count + 17'd1;
    end
  end
`endif

  assign bus.vga_plot  = plot;
  assign bus.vga_x     = out_pix.x;
  assign bus.vga_y     = out_pix.y;
  assign bus.vga_color = out_pix.color;
  assign bus.vga_addr  = out_addr;

  assign idle = fifo_empty && !plot;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue (DEPTH=16, 320x240).
module tb_pixel_write_queue;

  logic clock = 1'b0;
  logic reset;
  logic full;
  logic overflow;
  logic idle;
`ifdef PWQ_STATS_EN
  logic [16:0] pix_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int          obs_rd = 0;

  pixel_write_queue_if bus();

  pixel_write_queue #(
    .DEPTH    (16),
    .SCREEN_W (320),
    .SCREEN_H (240)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .full     (full),
    .overflow (overflow),
    .idle     (idle)
`ifdef PWQ_STATS_EN
    ,
    .pix_count(pix_count)
`endif
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Monitor: record every pixel the adapter takes.
  always @(negedge clock) begin
    if (!reset && bus.vga_plot && bus.vga_ready)
      obs_q.push_back({bus.vga_x, bus.vga_y, bus.vga_color, bus.vga_addr});
  end

  function automatic logic [36:0] model(input int x, input int y, input int c);
    return {9'(x), 8'(y), 3'(c), 17'(y * 320 + x)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // Drive one strobe cycle; keep=1 means the pixel must come out later.
  task automatic drive(input int x, input int y, input int c, input bit keep);
    bus.in_valid = 1'b1;
    bus.in_x     = 9'(x);
    bus.in_y     = 8'(y);
    bus.in_color = 3'(c);
    if (keep) exp_q.push_back(model(x, y, c));
    tick();
  endtask

  task automatic stop_in();
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: count and in-order compare of retired pixels.
  task automatic drain_check(input string tag);
    chk({tag, "_n"}, 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      chk(tag, 64'(obs_q[obs_rd]), 64'(exp_q.pop_front()));
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    int base;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_color  = '0;
    bus.vga_ready = 1'b0;

    // Step 1: reset values and single pixel latency.
    do_reset();
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_x", bus.vga_x, 0);
    chk("rst_y", bus.vga_y, 0);
    chk("rst_color", bus.vga_color, 0);
    chk("rst_addr", bus.vga_addr, 0);
    chk("rst_idle", idle, 1);
    bus.vga_ready = 1'b1;
    drive(10, 5, 5, 1'b1);
    stop_in();
    chk("s1_plot", bus.vga_plot, 1);
    chk("s1_addr", bus.vga_addr, 1610);
    chk("s1_x", bus.vga_x, 10);
    chk("s1_y", bus.vga_y, 5);
    chk("s1_color", bus.vga_color, 5);
    chk("s1_idle_busy", idle, 0);
    tick();
    chk("s1_idle", idle, 1);
    chk("s1_plot_off", bus.vga_plot, 0);
    drain_check("s1_stream");

    // Step 2: full-row burst on the last line.
    for (int x = 0; x < 320; x++) drive(x, 239, x % 8, 1'b1);
    stop_in();
    repeat (3) tick();
    chk("s2_last_addr", 64'(obs_q[obs_q.size() - 1][16:0]), 76799);
    chk("s2_ovf", overflow, 0);
    chk("s2_idle", idle, 1);
    drain_check("s2_stream");
`ifdef PWQ_STATS_EN
    chk("s2_pix_count", pix_count, 321);
    drive(0, 0, 1, 1'b1);
    stop_in();
    chk("st_clear", pix_count, 0);
    tick();
    chk("st_after_clear", pix_count, 1);
    drain_check("st_stream");
`endif

    // Step 3: backpressure, fill, overflow, then drain.
    do_reset();
    bus.vga_ready = 1'b0;
    for (int k = 0; k < 17; k++) drive(k, 1, k % 8, 1'b1);
    stop_in();
    chk("s3_full", full, 1);
    chk("s3_ovf_before", overflow, 0);
    chk("s3_plot_held", bus.vga_plot, 1);
    chk("s3_x_held", bus.vga_x, 0);
    drive(100, 1, 2, 1'b0);
    stop_in();
    chk("s3_ovf", overflow, 1);
    chk("s3_full_after", full, 1);
    chk("s3_x_still", bus.vga_x, 0);
    bus.vga_ready = 1'b1;
    repeat (20) tick();
    drain_check("s3_stream");
    chk("s3_full_drained", full, 0);
    chk("s3_idle", idle, 1);
    chk("s3_ovf_sticky", overflow, 1);

    // Step 4: push into a full queue while the adapter pops.
    do_reset();
    bus.vga_ready = 1'b0;
    for (int k = 0; k < 17; k++) drive(k, 2, 7 - (k % 8), 1'b1);
    stop_in();
    chk("s4_full", full, 1);
    bus.vga_ready = 1'b1;
    drive(50, 2, 7, 1'b1);
    stop_in();
    chk("s4_ovf", overflow, 0);
    chk("s4_full_kept", full, 1);
    repeat (20) tick();
    drain_check("s4_stream");
    chk("s4_idle", idle, 1);

    // Step 5: off-screen pixels are filtered.
    do_reset();
    bus.vga_ready = 1'b1;
    drive(320, 0, 1, 1'b0);
    stop_in();
    chk("s5_plot_x", bus.vga_plot, 0);
    chk("s5_idle_x", idle, 1);
    drive(0, 240, 2, 1'b0);
    stop_in();
    chk("s5_plot_y", bus.vga_plot, 0);
    chk("s5_idle_y", idle, 1);
    chk("s5_ovf", overflow, 0);
    tick();
    chk("s5_plot_late", bus.vga_plot, 0);
    drain_check("s5_stream");

    // Step 6: reset with pixels pending discards everything.
    do_reset();
    bus.vga_ready = 1'b0;
    for (int k = 0; k < 9; k++) drive(k + 20, 3, k % 8, 1'b0);
    stop_in();
    chk("s6_busy", idle, 0);
    chk("s6_plot_pre", bus.vga_plot, 1);
    reset = 1'b1;
    #1;
    chk("s6_plot_rst", bus.vga_plot, 0);
    chk("s6_idle_rst", idle, 1);
    chk("s6_full_rst", full, 0);
`ifdef PWQ_STATS_EN
    chk("s6_pix_count", pix_count, 0);
`endif
    tick();
    reset = 1'b0;
    base = obs_q.size();
    bus.vga_ready = 1'b1;
    repeat (10) tick();
    chk("s6_no_output", 64'(obs_q.size() - base), 0);
    chk("s6_plot_after", bus.vga_plot, 0);
    chk("s6_idle_after", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
